// File: rtl/connect4_pkg.sv
// connect4_pkg
//   Shared types and constants for the Connect-4 board controller link to the
//   Arduino opponent.
//   - spi_tx_state_t : state encoding of the outbound SPI move transmitter
//   - frame_state_t  : game-state codes carried in the FRM_STATE field
//   - FRM_*          : bit positions of the fields inside one 8-bit frame
//   - SPI_CLK_DIV_DEFAULT : system clocks per sck half-period (50 MHz -> 1 MHz)
//   - build_frame()  : packs the frame fields into one byte
package connect4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_WAIT_ACK = 3'd4
  } spi_tx_state_t;

  typedef enum logic [1:0] {
    FS_PLAY   = 2'b00,
    FS_P1_WIN = 2'b01,
    FS_P2_WIN = 2'b10,
    FS_DRAW   = 2'b11
  } frame_state_t;

  localparam int FRM_W        = 8;
  localparam int FRM_STATE_HI = 7;
  localparam int FRM_STATE_LO = 6;
  localparam int FRM_PLAYER   = 5;
  localparam int FRM_COL_HI   = 4;
  localparam int FRM_COL_LO   = 2;
  localparam int FRM_SEQ_HI   = 1;
  localparam int FRM_SEQ_LO   = 0;

  localparam int SPI_CLK_DIV_DEFAULT = 25;

  function automatic logic [FRM_W-1:0] build_frame(
    input frame_state_t st,
    input logic         player,
    input logic [2:0]   col,
    input logic [1:0]   seq
  );
    logic [FRM_W-1:0] f;
    f = '0;
    f[FRM_STATE_HI:FRM_STATE_LO] = st;
    f[FRM_PLAYER]                = player;
    f[FRM_COL_HI:FRM_COL_LO]     = col;
    f[FRM_SEQ_HI:FRM_SEQ_LO]     = seq;
    return f;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div
//   Half-period tick generator for the SPI transmitter. The counter runs
//   0..CLK_DIV-1 while en=1 and is forced to 0 by clr (clr wins over en).
//   Ports:
//     clk, rst : system clock, asynchronous active-low reset
//     en       : count enable (transmitter outside IDLE)
//     clr      : synchronous clear (state change in the transmitter)
//     tick     : high while enabled and the counter sits at CLK_DIV-1
module spi_clk_div #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // tick deliberately ignores clr: clr is derived from the next state, which
  // itself depends on tick.
  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_move_tx.sv
// spi_move_tx
//   SPI mode-0 master that sends one DATA_W-bit frame (MSB first) from the
//   board controller to the Arduino opponent.
//   Optional feature macro: SPI_TX_ACK_EN (wait for an ack edge after each
//   frame, resend on timeout, report err when retries run out).
//   Ports:
//     clk, rst   : system clock, asynchronous active-low reset
//     start,data : request and frame; sampled only while ready=1
//     ready/busy : idle-and-accepting / transaction in progress
//     done, err  : one-cycle end-of-transaction pulse, err valid with done
//     ack        : asynchronous acknowledge from the Arduino
//     sck,ss,mosi: SPI clock (CPOL=0), active-low select, serial data
//     dbg_state  : current FSM state (spi_tx_state_t encoding)
//   Handshake: a request is taken in any cycle where start=1 and ready=1;
//   ready is high in the done cycle, so a frame can follow back to back.
//   Timing: SETUP (1 half-period) + SHIFT (2*DATA_W half-periods) + HOLD
//   (1 half-period), done rising (2*DATA_W+2)*CLK_DIV clocks after the
//   acceptance edge.
module spi_move_tx
  import connect4_pkg::*;
#(
  parameter int CLK_DIV     = SPI_CLK_DIV_DEFAULT,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 50000,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              ack,
  output logic              sck,
  output logic              ss,
  output logic              mosi,
  output logic [2:0]        dbg_state
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W);

  spi_tx_state_t     state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              sck_q, sck_d;
  logic              ss_q, ss_d;
  logic              done_q, done_d;
  logic              tick;

`ifdef SPI_TX_ACK_EN
  localparam int WCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(ACK_TIMEOUT - 1);
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRY);

  logic [DATA_W-1:0] frame_q, frame_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [RCW-1:0]    retry_q, retry_d;
  logic              err_q, err_d;
  logic              ack_s1_q, ack_s2_q, ack_s3_q;
  logic              ack_rise, ack_timeout;

  // s1/s2 synchronise, s3 remembers the previous synchronised level.
  assign ack_rise    = ack_s2_q & ~ack_s3_q;
  assign ack_timeout = (wait_cnt_q == WAIT_LAST);
`else
  logic        unused_ack;
  logic [31:0] unused_params;
  assign unused_ack    = ack;
  assign unused_params = ACK_TIMEOUT ^ MAX_RETRY;
`endif

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .clr  (state_d != state_q),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      // Leave SHIFT at the end of the low half-period that follows the last
      // falling edge, instead of producing another rising edge.
      ST_SHIFT: if (tick && !sck_q && (bit_cnt_q == BIT_LAST)) state_d = ST_HOLD;
`ifdef SPI_TX_ACK_EN
      ST_HOLD:  if (tick) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (ack_rise) begin
          state_d = ST_IDLE;
        end else if (ack_timeout) begin
          state_d = (retry_q == RETRY_MAX) ? ST_IDLE : ST_SETUP;
        end
      end
`else
      ST_HOLD:  if (tick) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    ss_d      = ss_q;
    done_d    = 1'b0;
`ifdef SPI_TX_ACK_EN
    frame_d    = frame_q;
    wait_cnt_d = '0;
    retry_d    = retry_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_d      = data;
          bit_cnt_d = '0;
          sck_d     = 1'b0;
          ss_d      = 1'b0;
`ifdef SPI_TX_ACK_EN
          frame_d = data;
          retry_d = '0;
`endif
        end
      end
      ST_SETUP: begin
        if (tick) begin
          sck_d     = 1'b1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sck_q) begin
            // Falling edge: next bit onto mosi. Zeros shift in, so mosi is
            // already 0 after the last bit.
            sck_d = 1'b0;
            sh_d  = {sh_q[DATA_W-2:0], 1'b0};
          end else if (bit_cnt_q != BIT_LAST) begin
            sck_d     = 1'b1;
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          ss_d = 1'b1;
`ifndef SPI_TX_ACK_EN
          done_d = 1'b1;
`endif
        end
      end
`ifdef SPI_TX_ACK_EN
      ST_WAIT_ACK: begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
        if (ack_rise) begin
          done_d = 1'b1;
        end else if (ack_timeout) begin
          if (retry_q == RETRY_MAX) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            retry_d   = retry_q + RCW'(1);
            sh_d      = frame_q;
            bit_cnt_d = '0;
            ss_d      = 1'b0;
          end
        end
      end
`endif
      default: begin
        sh_d  = '0;
        sck_d = 1'b0;
        ss_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q      <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      ss_q      <= ss_d;
      done_q    <= done_d;
    end
  end

`ifdef SPI_TX_ACK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q    <= '0;
      wait_cnt_q <= '0;
      retry_q    <= '0;
      err_q      <= 1'b0;
      ack_s1_q   <= 1'b0;
      ack_s2_q   <= 1'b0;
      ack_s3_q   <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      wait_cnt_q <= wait_cnt_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      ack_s1_q   <= ack;
      ack_s2_q   <= ack_s1_q;
      ack_s3_q   <= ack_s2_q;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ready     = (state_q == ST_IDLE);
  assign busy      = ~ready;
  assign done      = done_q;
  assign sck       = sck_q;
  assign ss        = ss_q;
  assign mosi      = sh_q[DATA_W-1];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_move_tx.sv
// tb_spi_move_tx
//   Randomised and directed bench for spi_move_tx (CLK_DIV=2, DATA_W=8).
//   An SPI monitor rebuilds each frame from mosi on sck rising edges and
//   compares it with an expected queue. The transaction model treats a frame
//   as a fixed-length busy interval of (2*DATA_W+2)*CLK_DIV clocks.
//   With SPI_TX_ACK_EN defined, directed ack / retry scenarios run instead.
module tb_spi_move_tx;
  import connect4_pkg::*;

  localparam int CLK_DIV     = 2;
  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 100;
  localparam int MAX_RETRY   = 3;
  localparam int FRAME_CYC   = (2 * DATA_W + 2) * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [DATA_W-1:0] data;
  logic ack;
  logic ready, busy, done, err, sck, ss, mosi;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  spi_move_tx #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W),
    .ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .ready(ready), .busy(busy), .done(done), .err(err),
    .ack(ack), .sck(sck), .ss(ss), .mosi(mosi), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];
  int frames_seen = 0;
  int done_cnt    = 0;
  logic [DATA_W-1:0] mon_word = '0;
  int mon_edges = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SPI monitor: one frame per ss-low window
  always @(negedge ss) begin
    mon_word  = '0;
    mon_edges = 0;
  end

  always @(posedge sck) begin
    if (rst && !ss) begin
      mon_word = {mon_word[DATA_W-2:0], mosi};
      mon_edges++;
    end
  end

  always @(posedge ss) begin
    if (rst) begin
      frames_seen++;
      check("exp_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("frame_bits", mon_word, exp_q.pop_front());
        check("frame_edges", mon_edges, DATA_W);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && done) done_cnt++;
  end

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

`ifndef SPI_TX_ACK_EN
  // ---------------- transaction model ----------------
  // A request is taken whenever no frame is outstanding; the frame then
  // occupies exactly FRAME_CYC clocks and done marks the first free cycle.
  int   remain   = 0;
  logic exp_done = 1'b0;
  bit   model_on = 1'b0;
  logic [DATA_W-1:0] dropped;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (remain > 0) dropped = exp_q.pop_back();
      remain   = 0;
      exp_done = 1'b0;
    end else if (remain == 0) begin
      exp_done = 1'b0;
      if (start) begin
        exp_q.push_back(data);
        remain = FRAME_CYC;
      end
    end else begin
      remain--;
      exp_done = (remain == 0);
    end
  end

  always @(negedge clk) begin
    if (rst && model_on) begin
      check("ready", ready, remain == 0);
      check("busy", busy, remain != 0);
      check("done", done, exp_done);
      if (done) check("err_with_done", err, 0);
      if (ss) check("sck_idle_low", sck, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_and_measure(input logic [DATA_W-1:0] d);
    int lat;
    @(negedge clk);
    data  = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
    check("latency", lat, FRAME_CYC);
  endtask

  task automatic wait_edges(input int k, input string tag);
    int n;
    n = 0;
    while (mon_edges < k && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, mon_edges, k);
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    int dc0;
    int fs0;
    int n;
    rst   = 1'b0;
    start = 1'b0;
    data  = '0;
    ack   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ss", ss, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    rst = 1'b1;
    @(negedge clk);

`ifndef SPI_TX_ACK_EN
    model_on = 1'b1;

    // Basic frame and a packed game frame
    send_and_measure(8'hA5);
    send_and_measure(build_frame(FS_P2_WIN, 1'b1, 3'd5, 2'd2));

    // Start while busy is ignored
    @(negedge clk);
    data  = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = DATA_W'($urandom);
    dc0   = done_cnt;
    wait_edges(3, "reach_bit3");
    data  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, "ignore");
    repeat (5) @(negedge clk);
    check("single_done", done_cnt - dc0, 1);

    // Start held high: back-to-back frames, ss high for the done cycle only
    data  = 8'h3C;
    start = 1'b1;
    wait_done(200, "b2b_first");
    check("b2b_gap_ss_high", ss, 1);
    @(negedge clk);
    check("b2b_second_ss_low", ss, 0);
    check("b2b_second_busy", busy, 1);
    start = 1'b0;
    @(negedge clk);
    wait_done(200, "b2b_second");
    @(negedge clk);

    // Asynchronous reset mid-frame
    data  = 8'hC3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edges(4, "reach_bit4");
    dc0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    check("arst_ss", ss, 1);
    check("arst_sck", sck, 0);
    check("arst_mosi", mosi, 0);
    check("arst_ready", ready, 1);
    repeat (3) @(negedge clk);
    check("arst_no_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    check("arst_ready_after", ready, 1);
    send_and_measure(8'h81);
    repeat (5) @(negedge clk);
    check("arst_done_count", done_cnt - dc0, 1);

    // Random traffic: random data every cycle, sparse random start
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      data  = DATA_W'($urandom);
      start = ($urandom_range(0, 9) < 3);
    end
    start = 1'b0;
    repeat (FRAME_CYC + 5) @(negedge clk);
`else
    // Ack arrives 40 clocks after ss rises: single frame, err=0
    exp_q.push_back(8'h96);
    fs0 = frames_seen;
    @(negedge clk);
    data  = 8'h96;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = DATA_W'($urandom);
    n = 0;
    while (!(ss && busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ack_wait_entered", ss && busy, 1);
    repeat (40) @(negedge clk);
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    wait_done(200, "ack_ok");
    check("ack_ok_err", err, 0);
    check("ack_ok_frames", frames_seen - fs0, 1);
    @(negedge clk);
    check("ack_ok_ready", ready, 1);

    // No ack at all: first attempt plus MAX_RETRY resends, then err
    for (int i = 0; i <= MAX_RETRY; i++) exp_q.push_back(8'h69);
    fs0 = frames_seen;
    @(negedge clk);
    data  = 8'h69;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = DATA_W'($urandom);
    wait_done((MAX_RETRY + 1) * (FRAME_CYC + ACK_TIMEOUT) + 100, "retry");
    check("retry_err", err, 1);
    check("retry_frames", frames_seen - fs0, MAX_RETRY + 1);
    @(negedge clk);
    check("retry_ready", ready, 1);
    check("retry_busy", busy, 0);
    repeat (5) @(negedge clk);
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
